// File: rtl/weight_memory_loader_if.sv
// Valid/ready beat stream from the host/DMA into the weight memory loader.
// Ports: s_valid/s_data driven by the source (master), s_ready driven by the loader (slave).
// IN_WIDTH sets the beat width; lane l of a beat sits at bits [8*(l+1)-1:8*l] for 8-bit lanes.
interface weight_memory_loader_if #(
    parameter int IN_WIDTH = 32
);
    logic                s_valid;
    logic                s_ready;
    logic [IN_WIDTH-1:0] s_data;

    modport master (output s_valid, output s_data, input  s_ready);
    modport slave  (input  s_valid, input  s_data, output s_ready);
endinterface

// File: rtl/weight_memory_loader.sv
// Packs IN_WIDTH stream beats into N_DIM_ARRAY-lane weight words and writes them to the FC or CNN port of one bank.
// Latency: first write BEATS+1 cycles after start with a steady stream; one word per BEATS+1 cycles; done the cycle after the last write.
// Backpressure: s_ready is high only in FILL (dropped for the WRITE cycle); a low s_valid simply stalls packing.
// Ports: clk/reset, start + cfg_* (captured at start), stream slave interface s, FC and CNN write ports, busy/done/err_cfg.
module weight_memory_loader #(
    parameter int N_DIM_ARRAY             = 8,
    parameter int WEIGHT_DATA_WIDTH       = 8,
    parameter int WEIGHT_MEMORY_ADDR_SIZE = 16,
    parameter int IN_WIDTH                = 32
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 start,
    input  logic [2:0]                           cfg_mode,
    input  logic                                 cfg_bank,
    input  logic [WEIGHT_MEMORY_ADDR_SIZE-2:0]   cfg_base_addr,
    input  logic [WEIGHT_MEMORY_ADDR_SIZE-1:0]   cfg_num_words,
    weight_memory_loader_if.slave                s,
    output logic                                 wr_en_ext_fc_w,
    output logic [WEIGHT_MEMORY_ADDR_SIZE-1:0]   wr_addr_ext_fc_w,
    output logic signed [N_DIM_ARRAY-1:0][WEIGHT_DATA_WIDTH-1:0] wr_data_ext_fc_w,
    output logic                                 wr_en_ext_cnn_w,
    output logic [WEIGHT_MEMORY_ADDR_SIZE-1:0]   wr_addr_ext_cnn_w,
    output logic signed [N_DIM_ARRAY-1:0][WEIGHT_DATA_WIDTH-1:0] wr_data_ext_cnn_w,
    output logic                                 busy,
    output logic                                 done,
    output logic                                 err_cfg
);
    localparam int WORD_W = N_DIM_ARRAY * WEIGHT_DATA_WIDTH;
    localparam int BEATS  = WORD_W / IN_WIDTH;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int AW     = WEIGHT_MEMORY_ADDR_SIZE;

    localparam logic [2:0] MODE_FC  = 3'd0;
    localparam logic [2:0] MODE_CNN = 3'd1;

    typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_t;

    state_t              state;
    logic [BEAT_W-1:0]   beat_cnt;
    logic [AW-1:0]       word_cnt;
    logic [WORD_W-1:0]   pack;
    logic                is_cnn;
    logic                bank_q;
    logic [AW-2:0]       base_q;
    logic [AW-1:0]       num_q;
    logic                s_ready_q;

    logic [WORD_W-1:0]   pack_next;
    logic [31:0]         beat_off;
    logic [AW-2:0]       wr_off;
    logic [AW-1:0]       wr_addr_next;

    assign s.s_ready = s_ready_q;

    // Current beat merged into the pack register; used both to update the
    // register and to launch the write on the final beat of a word.
    assign beat_off = 32'(beat_cnt) * 32'(IN_WIDTH);

    always_comb begin
        pack_next = pack;
        pack_next[beat_off +: IN_WIDTH] = s.s_data;
    end

    // Offset addition is kept AW-1 bits wide so it wraps inside the bank and
    // never carries into the bank-select bit.
    assign wr_off       = base_q + word_cnt[AW-2:0];
    assign wr_addr_next = {bank_q, wr_off};

    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= IDLE;
            beat_cnt          <= '0;
            word_cnt          <= '0;
            pack              <= '0;
            is_cnn            <= 1'b0;
            bank_q            <= 1'b0;
            base_q            <= '0;
            num_q             <= '0;
            s_ready_q         <= 1'b0;
            wr_en_ext_fc_w    <= 1'b0;
            wr_addr_ext_fc_w  <= '0;
            wr_data_ext_fc_w  <= '0;
            wr_en_ext_cnn_w   <= 1'b0;
            wr_addr_ext_cnn_w <= '0;
            wr_data_ext_cnn_w <= '0;
            busy              <= 1'b0;
            done              <= 1'b0;
            err_cfg           <= 1'b0;
        end else begin
            // Write ports and done are single-cycle; default them off.
            done              <= 1'b0;
            wr_en_ext_fc_w    <= 1'b0;
            wr_addr_ext_fc_w  <= '0;
            wr_data_ext_fc_w  <= '0;
            wr_en_ext_cnn_w   <= 1'b0;
            wr_addr_ext_cnn_w <= '0;
            wr_data_ext_cnn_w <= '0;

            case (state)
                IDLE: begin
                    if (start) begin
                        if (cfg_mode != MODE_FC && cfg_mode != MODE_CNN) begin
                            err_cfg <= 1'b1;
                        end else begin
                            err_cfg  <= 1'b0;
                            is_cnn   <= (cfg_mode == MODE_CNN);
                            bank_q   <= cfg_bank;
                            base_q   <= cfg_base_addr;
                            num_q    <= cfg_num_words;
                            beat_cnt <= '0;
                            word_cnt <= '0;
                            pack     <= '0;
                            if (cfg_num_words == '0) begin
                                state <= DONE;
                                done  <= 1'b1;
                            end else begin
                                state     <= FILL;
                                s_ready_q <= 1'b1;
                                busy      <= 1'b1;
                            end
                        end
                    end
                end

                FILL: begin
                    if (s.s_valid && s_ready_q) begin
                        pack <= pack_next;
                        if (beat_cnt == BEAT_W'(BEATS - 1)) begin
                            state     <= WRITE;
                            s_ready_q <= 1'b0;
                            beat_cnt  <= '0;
                            if (is_cnn) begin
                                wr_en_ext_cnn_w   <= 1'b1;
                                wr_addr_ext_cnn_w <= wr_addr_next;
                                wr_data_ext_cnn_w <= pack_next;
                            end else begin
                                wr_en_ext_fc_w    <= 1'b1;
                                wr_addr_ext_fc_w  <= wr_addr_next;
                                wr_data_ext_fc_w  <= pack_next;
                            end
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end
                end

                WRITE: begin
                    word_cnt <= word_cnt + 1'b1;
                    if (word_cnt + 1'b1 == num_q) begin
                        state <= DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end else begin
                        state     <= FILL;
                        s_ready_q <= 1'b1;
                    end
                end

                DONE: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_weight_memory_loader.sv
// Scoreboard bench for weight_memory_loader: expected writes are queued when a load is launched
// and popped as the DUT strobes either write port; timing is checked against start cycle.
module tb_weight_memory_loader;
    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  cfg_mode;
    logic        cfg_bank;
    logic [14:0] cfg_base_addr;
    logic [15:0] cfg_num_words;
    logic        fc_en, cnn_en, busy, done, err_cfg;
    logic [15:0] fc_addr, cnn_addr;
    logic signed [7:0][7:0] fc_data, cnn_data;

    typedef struct {
        logic        cnn;
        logic [15:0] addr;
        logic [63:0] data;
    } wr_t;

    wr_t sb[$];
    int  wcyc[$];
    int  cyc = 0;
    int  total = 0;
    int  bad = 0;
    int  last_acc;
    int  sc, dc;
    logic busy_seen;

    weight_memory_loader_if #(.IN_WIDTH(32)) s_if ();

    weight_memory_loader dut (
        .clk               (clk),
        .reset             (reset),
        .start             (start),
        .cfg_mode          (cfg_mode),
        .cfg_bank          (cfg_bank),
        .cfg_base_addr     (cfg_base_addr),
        .cfg_num_words     (cfg_num_words),
        .s                 (s_if),
        .wr_en_ext_fc_w    (fc_en),
        .wr_addr_ext_fc_w  (fc_addr),
        .wr_data_ext_fc_w  (fc_data),
        .wr_en_ext_cnn_w   (cnn_en),
        .wr_addr_ext_cnn_w (cnn_addr),
        .wr_data_ext_cnn_w (cnn_data),
        .busy              (busy),
        .done              (done),
        .err_cfg           (err_cfg)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Byte stream: consecutive byte values, lane 0 in the low byte.
    function automatic logic [31:0] beat_of(input logic [7:0] b);
        logic [31:0] r;
        for (int l = 0; l < 4; l++) r[8*l +: 8] = 8'(b + 8'(l));
        return r;
    endfunction

    function automatic logic [63:0] word_of(input logic [7:0] b);
        logic [63:0] r;
        for (int l = 0; l < 8; l++) r[8*l +: 8] = 8'(b + 8'(l));
        return r;
    endfunction

    // Monitor: every strobe is matched against the scoreboard; idle ports must be all zero.
    always @(negedge clk) begin
        wr_t e;
        if (fc_en || cnn_en) begin
            wcyc.push_back(cyc);
            chk("ready_in_write", {63'd0, s_if.s_ready}, 64'd0);
            chk("busy_in_write", {63'd0, busy}, 64'd1);
            if (sb.size() == 0) begin
                chk("unexpected_write", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                chk("wr_port_cnn", {63'd0, cnn_en}, {63'd0, e.cnn});
                chk("wr_both_ports", {63'd0, fc_en & cnn_en}, 64'd0);
                chk("wr_addr", {48'd0, cnn_en ? cnn_addr : fc_addr}, {48'd0, e.addr});
                chk("wr_data", cnn_en ? cnn_data : fc_data, e.data);
            end
        end
        if (!fc_en)  chk("fc_idle", {fc_addr, 48'd0} | fc_data, 64'd0);
        if (!cnn_en) chk("cnn_idle", {cnn_addr, 48'd0} | cnn_data, 64'd0);
        if (busy) busy_seen = 1'b1;
    end

    // Called at a negedge; returns at the negedge after the beat is accepted.
    task automatic send_beat(input logic [31:0] d, input int gap);
        int n;
        repeat (gap) begin
            s_if.s_valid = 1'b0;
            @(negedge clk);
        end
        s_if.s_valid = 1'b1;
        s_if.s_data  = d;
        n = 0;
        while (!s_if.s_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("beat_timeout", 64'd1, 64'd0);
        last_acc = cyc;
        @(negedge clk);
    endtask

    task automatic wait_done(output int c);
        int n;
        n = 0;
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("done_timeout", 64'd1, 64'd0);
        c = cyc;
        @(negedge clk);
    endtask

    task automatic pulse_start(input logic [2:0] mode, input logic bank,
                               input logic [14:0] base, input logic [15:0] num, output int c);
        @(negedge clk);
        cfg_mode = mode; cfg_bank = bank; cfg_base_addr = base; cfg_num_words = num;
        start = 1'b1;
        c = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic push_exp(input logic [2:0] mode, input logic bank, input logic [14:0] base,
                            input int nw, input logic [7:0] b0);
        wr_t e;
        logic [14:0] off;
        for (int w = 0; w < nw; w++) begin
            off    = base + 15'(w);
            e.cnn  = (mode == 3'd1);
            e.addr = {bank, off};
            e.data = word_of(8'(b0 + 8'(8 * w)));
            sb.push_back(e);
        end
    endtask

    task automatic run_load(input logic [2:0] mode, input logic bank, input logic [14:0] base,
                            input logic [15:0] num, input int gap, input logic [7:0] b0,
                            output int s_c, output int d_c);
        push_exp(mode, bank, base, int'(num), b0);
        pulse_start(mode, bank, base, num, s_c);
        for (int k = 0; k < 2 * int'(num); k++)
            send_beat(beat_of(8'(b0 + 8'(4 * k))), (k % 2 == 1) ? gap : 0);
        s_if.s_valid = 1'b0;
        wait_done(d_c);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; cfg_mode = '0; cfg_bank = 1'b0;
        cfg_base_addr = '0; cfg_num_words = '0;
        s_if.s_valid = 1'b0; s_if.s_data = '0;
        busy_seen = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_outputs", {58'd0, fc_en, cnn_en, busy, done, err_cfg, s_if.s_ready}, 64'd0);
        chk("rst_addrs", {32'd0, fc_addr, cnn_addr}, 64'd0);

        // FC, bank 0, 3 words, stream held high.
        wcyc.delete();
        run_load(3'd0, 1'b0, 15'h0010, 16'd3, 0, 8'h00, sc, dc);
        chk("fc_nwrites", 64'(wcyc.size()), 64'd3);
        if (wcyc.size() == 3) begin
            chk("fc_w0_cycle", 64'(wcyc[0] - sc), 64'd3);
            chk("fc_w1_cycle", 64'(wcyc[1] - sc), 64'd6);
            chk("fc_w2_cycle", 64'(wcyc[2] - sc), 64'd9);
        end
        chk("fc_done_cycle", 64'(dc - sc), 64'd10);
        chk("fc_sb_empty", 64'(sb.size()), 64'd0);
        chk("fc_busy_after", {63'd0, busy}, 64'd0);

        // CNN, bank 1, offset wraps from 0x7FFF to 0x0000 inside the bank.
        wcyc.delete();
        run_load(3'd1, 1'b1, 15'h7FFF, 16'd2, 0, 8'h30, sc, dc);
        chk("cnn_nwrites", 64'(wcyc.size()), 64'd2);
        chk("cnn_sb_empty", 64'(sb.size()), 64'd0);

        // Backpressure: valid pattern 1,0,0,1 for one word.
        wcyc.delete();
        run_load(3'd0, 1'b0, 15'h0200, 16'd1, 2, 8'h80, sc, dc);
        chk("bp_nwrites", 64'(wcyc.size()), 64'd1);
        if (wcyc.size() == 1) chk("bp_write_cycle", 64'(wcyc[0] - last_acc), 64'd1);
        chk("bp_sb_empty", 64'(sb.size()), 64'd0);

        // Zero words: immediate done, busy never rises, no writes.
        wcyc.delete();
        busy_seen = 1'b0;
        run_load(3'd0, 1'b0, 15'h0040, 16'd0, 0, 8'h00, sc, dc);
        chk("zero_done_cycle", 64'(dc - sc), 64'd1);
        chk("zero_busy_seen", {63'd0, busy_seen}, 64'd0);
        chk("zero_nwrites", 64'(wcyc.size()), 64'd0);

        // Illegal mode flags err_cfg and stays idle; next legal start clears it.
        wcyc.delete();
        pulse_start(3'd3, 1'b0, 15'h0000, 16'd2, sc);
        chk("ill_err", {63'd0, err_cfg}, 64'd1);
        chk("ill_busy", {62'd0, busy, s_if.s_ready}, 64'd0);
        repeat (5) @(negedge clk);
        chk("ill_err_sticky", {63'd0, err_cfg}, 64'd1);
        chk("ill_nwrites", 64'(wcyc.size()), 64'd0);
        run_load(3'd1, 1'b0, 15'h0100, 16'd1, 0, 8'hC0, sc, dc);
        chk("ill_err_cleared", {63'd0, err_cfg}, 64'd0);
        chk("ill_sb_empty", 64'(sb.size()), 64'd0);

        // Reset after the first beat of word 1 in a 4-word load.
        wcyc.delete();
        push_exp(3'd0, 1'b0, 15'h0020, 1, 8'h40);
        pulse_start(3'd0, 1'b0, 15'h0020, 16'd4, sc);
        for (int k = 0; k < 3; k++) send_beat(beat_of(8'(8'h40 + 8'(4 * k))), 0);
        reset = 1'b1;
        s_if.s_valid = 1'b0;
        @(negedge clk);
        chk("mid_rst_outputs", {58'd0, fc_en, cnn_en, busy, done, err_cfg, s_if.s_ready}, 64'd0);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        chk("mid_rst_nwrites", 64'(wcyc.size()), 64'd1);
        chk("mid_rst_sb_empty", 64'(sb.size()), 64'd0);
        wcyc.delete();
        run_load(3'd0, 1'b0, 15'h0020, 16'd2, 0, 8'hA0, sc, dc);
        chk("post_rst_nwrites", 64'(wcyc.size()), 64'd2);
        chk("post_rst_sb_empty", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
